param_updown_counter: RTL
=========================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning counter width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 16, meaning count length; legal range 2..2**N.
REQ-003 The block SHALL have port Clock, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port Resetn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port En, input, 1 bit: count enable.
REQ-006 The block SHALL have port Up, input, 1 bit: direction; 1 = up, 0 = down.
REQ-007 The block SHALL have port Load, input, 1 bit: synchronous parallel load.
REQ-008 The block SHALL have port D, input, N bits: load value.
REQ-009 The block SHALL have port Q, output, N bits: registered count.
REQ-010 The block SHALL have port Tc, output, 1 bit: combinational terminal-count flag.
REQ-011 The block SHALL have port Carry, output, 1 bit: registered wrap pulse.
REQ-012 The block SHALL have port LoadErr, output, 1 bit: registered out-of-range-load pulse.

Function
REQ-013 Clocked-update priority SHALL be Load, then En, then hold.
REQ-014 With Load=1 and D < MODULUS, Q SHALL equal D after the edge; Carry=0, LoadErr=0.
REQ-015 With Load=1 and D >= MODULUS, Q SHALL equal MODULUS-1 after the edge; LoadErr=1 for exactly that cycle; Carry=0.
REQ-016 With Load=0, En=1, Up=1: Q < MODULUS-1 SHALL give Q+1; Q == MODULUS-1 SHALL give 0 with Carry=1 for one cycle.
REQ-017 With Load=0, En=1, Up=0: Q > 0 SHALL give Q-1; Q == 0 SHALL give MODULUS-1 with Carry=1 for one cycle.
REQ-018 With Load=0 and En=0, Q SHALL hold, and Carry and LoadErr SHALL be 0.
REQ-019 Carry and LoadErr SHALL each be 0 in every cycle not named in REQ-015..REQ-017.
REQ-020 Tc SHALL equal En & ~Load & (Up ? Q==MODULUS-1 : Q==0), with no clock delay.
REQ-021 A direction change SHALL take effect on the next enabled edge, with no extra latency or skipped value.
REQ-022 All compare and next-value arithmetic SHALL be N bits wide; Q SHALL never hold a value >= MODULUS.
REQ-023 With MODULUS == 2**N, wrap behaviour SHALL equal natural N-bit overflow/underflow, with Carry asserted on it.
REQ-024 Count latency SHALL be one Clock edge: Q, Carry and LoadErr all update on the same edge.
REQ-025 Elaboration SHALL fail if MODULUS < 2 or MODULUS > 2**N.

Reset
REQ-026 Resetn=0 SHALL force Q=0, Carry=0 and LoadErr=0 immediately, independent of Clock.
REQ-027 While Resetn=0, Load, En and Clock edges SHALL have no effect.
REQ-028 Reset asserted mid-count SHALL abort the count; the first enabled edge after Resetn rises SHALL give Q=1 (up) or Q=MODULUS-1 (down).
REQ-029 Deassertion of Resetn SHALL be treated as synchronous to Clock by the integrating design; the block adds no synchronizer.

Verification (N=4, MODULUS=10)
REQ-030 Up wrap: reset, En=1, Up=1 for 12 edges -> Q sequence 1..9,0,1,2; Carry=1 only in the cycle Q returns to 0; Tc=1 while Q=9.
REQ-031 Down wrap: reset, En=1, Up=0 for 3 edges -> Q=9,8,7; Carry=1 only in the cycle Q=9 follows 0; Tc=1 while Q=0.
REQ-032 Load priority: Q=5, Load=1, En=1, D=3 -> Q=3, Carry=0; then D=12 with Load=1 -> Q=9, LoadErr=1 for one cycle.
REQ-033 Hold and direction: Q=4, En=0 for 3 edges -> Q=4 and Tc=0; En=1, toggle Up each edge starting Up=1 -> Q=5,4,5,4.
REQ-034 Async reset: at Q=7, assert Resetn=0 mid-cycle -> Q=0 before the next Clock edge; release, En=1, Up=1 -> Q=1 after the first edge.
REQ-035 Full-range variant: N=4, MODULUS=16, Up=1 from Q=15 -> Q=0, Carry=1; Up=0 from Q=0 -> Q=15, Carry=1.

Source files
------------

// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous load, combinational terminal count,
// and one-cycle pulses for wrap and out-of-range loads.
module param_updown_counter #(
  parameter int N       = 4,
  parameter int MODULUS = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         En,
  input  logic         Up,
  input  logic         Load,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         Tc,
  output logic         Carry,
  output logic         LoadErr
);

  localparam logic [N-1:0] MAX_Q  = N'(MODULUS - 1);
  localparam logic [N-1:0] ZERO_Q = '0;
  localparam logic [N-1:0] ONE_Q  = N'(1);

  generate
    if ((MODULUS < 2) || (MODULUS > (2 ** N))) begin : g_bad_modulus
      $error("param_updown_counter: MODULUS must lie in 2..2**N");
    end
  endgenerate

  logic [N-1:0] q_r;
  logic [N-1:0] q_next_s;
  logic         carry_r;
  logic         carry_next_s;
  logic         load_err_r;
  logic         load_err_next_s;
  logic         at_max_s;
  logic         at_zero_s;

  assign at_max_s  = (q_r == MAX_Q);
  assign at_zero_s = (q_r == ZERO_Q);

  // Next count and pulse flags: load beats count beats hold.
  always_comb begin
    q_next_s        = q_r;
    carry_next_s    = 1'b0;
    load_err_next_s = 1'b0;
    if (Load) begin
      // D > MAX_Q is the N-bit form of D >= MODULUS; it is never true at full range.
      if (D > MAX_Q) begin
        q_next_s        = MAX_Q;
        load_err_next_s = 1'b1;
      end else begin
        q_next_s = D;
      end
    end else if (En) begin
      if (Up) begin
        if (at_max_s) begin
          q_next_s     = ZERO_Q;
          carry_next_s = 1'b1;
        end else begin
          q_next_s = q_r + ONE_Q;
        end
      end else begin
        if (at_zero_s) begin
          q_next_s     = MAX_Q;
          carry_next_s = 1'b1;
        end else begin
          q_next_s = q_r - ONE_Q;
        end
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Count and pulse registers, cleared asynchronously by Resetn.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q_r        <= ZERO_Q;
      carry_r    <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      q_r        <= q_next_s;
      carry_r    <= carry_next_s;
      load_err_r <= load_err_next_s;
    end
  end

  assign Q       = q_r;
  assign Carry   = carry_r;
  assign LoadErr = load_err_r;
  assign Tc      = En & ~Load & (Up ? at_max_s : at_zero_s);

endmodule
